// File: rtl/quad_encoder_gen.sv
// Quadrature pulse generator: emits Gray-coded A/B edges for a signed step count
// at a fixed per-move edge period, tracking the signed position a decoder would see.
module quad_encoder_gen #(
    parameter int WIDTH      = 32,
    parameter int PW         = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic [PW-1:0]    cmd_period,
    input  logic             abort,
    input  logic             pos_clr,
    output logic             quadA,
    output logic             quadB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] position
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [PW-1:0]    MIN_P = PW'(MIN_PERIOD);
    localparam logic [PW-1:0]    ONE_P = PW'(1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] r_position;
    logic [WIDTH-1:0] w_absSteps;
    logic [PW-1:0]    r_timer;
    logic [PW-1:0]    r_period;
    logic [PW-1:0]    w_cmdPeriod;
    logic             r_dir;
    logic             r_quadA;
    logic             r_quadB;
    logic             w_accept;
    logic             w_edgeDue;
    logic             w_emit;

    // The most negative step count maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_absSteps  = cmd_steps[WIDTH-1] ? (~cmd_steps + ONE_W) : cmd_steps;
    assign w_cmdPeriod = (cmd_period < MIN_P) ? MIN_P : cmd_period;
    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_edgeDue   = (r_state == S_RUN) && (r_timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort beats a due edge: the move stops without emitting it.
    always_comb begin
        w_next = r_state;
        w_emit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_edgeDue) begin
                    w_emit = 1'b1;
                    if (r_remaining == ONE_W) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_period    <= '0;
            r_timer     <= '0;
        end else if (w_accept) begin
            r_dir       <= ~cmd_steps[WIDTH-1];
            r_remaining <= w_absSteps;
            r_period    <= w_cmdPeriod;
            r_timer     <= w_cmdPeriod - ONE_P;
        end else if (r_state == S_RUN) begin
            if (abort) begin
                r_remaining <= '0;
                r_timer     <= '0;
            end else if (w_edgeDue) begin
                r_remaining <= r_remaining - ONE_W;
                r_timer     <= r_period - ONE_P;
            end else begin
                r_timer     <= r_timer - ONE_P;
            end
        end
    end

    // Forward toggles A when A==B, else B; reverse does the opposite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quadA <= 1'b0;
            r_quadB <= 1'b0;
        end else if (w_emit) begin
            if ((r_quadA == r_quadB) == r_dir) begin
                r_quadA <= ~r_quadA;
            end else begin
                r_quadB <= ~r_quadB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position <= '0;
        end else if (pos_clr) begin
            r_position <= '0;
        end else if (w_emit) begin
            r_position <= r_dir ? (r_position + ONE_W) : (r_position - ONE_W);
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign quadA     = r_quadA;
    assign quadB     = r_quadB;
    assign position  = r_position;

endmodule
